water_level_filter: RTL

//  Conditions the two raw water-probe inputs of the tank sensor (low probe, high probe).
//  It synchronises and debounces each probe, then classifies the tank level with a state machine.
//  It drives the 2-bit level code that the board top decodes onto SEG as letters A/N/B/D.

---
 rtl/water_level_filter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/water_level_filter.sv
// ---------------------------------------------------------------------------
// water_level_filter
//
// Conditions the two raw water probes of the tank sensor and turns them into a
// clean tank level. Each probe is synchronised into the clk_2 domain,
// debounced, and the resulting pair is classified by a small state machine.
// The state drives the 2-bit level code that the SEG decoder downstream shows
// as A/N/B/D. The block also drives a fill-pump command with hysteresis, a
// probe-fault alarm and a one-cycle level-change pulse.
//
// Parameters
//   STABLE_CYCLES : consecutive cycles a synchronised probe must disagree with
//                   its filtered value before the filtered value flips (>=1)
//   FAULT_CYCLES  : consecutive cycles of an invalid (or, in FAULT, a valid)
//                   probe pair needed to enter (or leave) FAULT (>=1)
//
// Ports
//   clk_2     in   1  system clock (divided board clock)
//   reset     in   1  asynchronous, active-high reset
//   sens_low  in   1  raw low probe, 1 = wet, asynchronous to clk_2
//   sens_high in   1  raw high probe, 1 = wet, asynchronous to clk_2
//   level     out  2  00 EMPTY, 01 MID, 10 FULL, 11 FAULT (registered)
//   pump_on   out  1  fill-pump command (registered)
//   alarm     out  1  high while level is FAULT (registered)
//   change    out  1  one-cycle pulse after the edge where level changed
// ---------------------------------------------------------------------------
module water_level_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int FAULT_CYCLES  = 3
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       sens_low,
    input  logic       sens_high,
    output logic [1:0] level,
    output logic       pump_on,
    output logic       alarm,
    output logic       change
);

    // The debounce and fault counters share one width, sized so the larger
    // of the two terminal counts fits.
    localparam int MAX_CYCLES = (STABLE_CYCLES > FAULT_CYCLES) ? STABLE_CYCLES : FAULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] FAULT_MAX  = CNT_W'(FAULT_CYCLES);

    // The state encoding is the level code itself, so level needs no decode.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MID   = 2'b01,
        ST_FULL  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    logic             low_s1_q,    low_s1_d;
    logic             low_s2_q,    low_s2_d;
    logic             high_s1_q,   high_s1_d;
    logic             high_s2_q,   high_s2_d;
    logic             low_filt_q,  low_filt_d;
    logic             high_filt_q, high_filt_d;
    logic [CNT_W-1:0] low_cnt_q,   low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q,  high_cnt_d;
    logic [CNT_W-1:0] fcnt_q,      fcnt_d;
    state_t           state_q,     state_d;
    logic             pump_on_q,   pump_on_d;
    logic             alarm_q,     alarm_d;
    logic             change_q,    change_d;

    logic             pair_valid;
    state_t           pair_class;
    logic [CNT_W-1:0] low_cnt_inc;
    logic [CNT_W-1:0] high_cnt_inc;
    logic [CNT_W-1:0] fcnt_inc;

    // Two-flop synchronisers: nothing downstream ever looks at the raw probes.
    always_comb begin
        low_s1_d  = sens_low;
        low_s2_d  = low_s1_q;
        high_s1_d = sens_high;
        high_s2_d = high_s1_q;
    end

    // Per-probe debounce. A probe only flips after disagreeing with its
    // filtered value for STABLE_CYCLES edges in a row; any agreeing edge
    // throws the partial count away, so short glitches never reach filt.
    always_comb begin
        low_cnt_inc  = low_cnt_q + 1'b1;
        low_filt_d   = low_filt_q;
        low_cnt_d    = '0;
        if (low_s2_q != low_filt_q) begin
            if (low_cnt_inc == STABLE_MAX) begin
                low_filt_d = low_s2_q;
            end else begin
                low_cnt_d = low_cnt_inc;
            end
        end

        high_cnt_inc = high_cnt_q + 1'b1;
        high_filt_d  = high_filt_q;
        high_cnt_d   = '0;
        if (high_s2_q != high_filt_q) begin
            if (high_cnt_inc == STABLE_MAX) begin
                high_filt_d = high_s2_q;
            end else begin
                high_cnt_d = high_cnt_inc;
            end
        end
    end

    // Classify the filtered pair. High wet with low dry is physically
    // impossible and marks a probe fault; pair_class is only meaningful
    // when pair_valid is set.
    always_comb begin
        pair_valid = !(high_filt_q && !low_filt_q);
        case ({high_filt_q, low_filt_q})
            2'b00:   pair_class = ST_EMPTY;
            2'b01:   pair_class = ST_MID;
            2'b11:   pair_class = ST_FULL;
            default: pair_class = ST_FAULT;
        endcase
    end

    // Level state machine. Valid pairs are followed immediately outside
    // FAULT; entering and leaving FAULT each need FAULT_CYCLES consecutive
    // edges of the opposite pair condition, and an interrupting edge resets
    // that count.
    always_comb begin
        fcnt_inc = fcnt_q + 1'b1;
        state_d  = state_q;
        fcnt_d   = '0;
        if (state_q != ST_FAULT) begin
            if (pair_valid) begin
                state_d = pair_class;
            end else if (fcnt_inc == FAULT_MAX) begin
                state_d = ST_FAULT;
            end else begin
                fcnt_d = fcnt_inc;
            end
        end else begin
            if (pair_valid) begin
                if (fcnt_inc == FAULT_MAX) begin
                    state_d = pair_class;
                end else begin
                    fcnt_d = fcnt_inc;
                end
            end
        end
    end

    // Output logic. The pump follows the current state (so it trails level
    // by one edge) and holds in MID, giving fill hysteresis between the two
    // probes. Alarm and change are computed from the next state so they line
    // up with the level register.
    always_comb begin
        case (state_q)
            ST_EMPTY: pump_on_d = 1'b1;
            ST_FULL:  pump_on_d = 1'b0;
            ST_FAULT: pump_on_d = 1'b0;
            default:  pump_on_d = pump_on_q;
        endcase
        alarm_d  = (state_d == ST_FAULT);
        change_d = (state_d != state_q);
    end

    // All state lives here; reset discards any partial debounce or fault
    // count along with the synchroniser contents.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            low_s1_q    <= 1'b0;
            low_s2_q    <= 1'b0;
            high_s1_q   <= 1'b0;
            high_s2_q   <= 1'b0;
            low_filt_q  <= 1'b0;
            high_filt_q <= 1'b0;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            fcnt_q      <= '0;
            state_q     <= ST_EMPTY;
            pump_on_q   <= 1'b0;
            alarm_q     <= 1'b0;
            change_q    <= 1'b0;
        end else begin
            low_s1_q    <= low_s1_d;
            low_s2_q    <= low_s2_d;
            high_s1_q   <= high_s1_d;
            high_s2_q   <= high_s2_d;
            low_filt_q  <= low_filt_d;
            high_filt_q <= high_filt_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            pump_on_q   <= pump_on_d;
            alarm_q     <= alarm_d;
            change_q    <= change_d;
        end
    end

    assign level   = state_q;
    assign pump_on = pump_on_q;
    assign alarm   = alarm_q;
    assign change  = change_q;

endmodule
